// File: rtl/enkel_pkg.sv
// enkel_pkg: opcodes, FSM state encoding and control-strobe decode for alu_sequencer
package enkel_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LDA   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_NOT   = 3'd3;
    localparam logic [2:0] OP_CLR   = 3'd4;
    localparam logic [2:0] OP_PCREL = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_B,
        S_EXEC,
        S_WRITE_A,
        S_CLEAR,
        S_DONE
    } state_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic aload;
        logic bload;
        logic areset;
        logic breset;
        logic latch_a_load;
        logic a_pc_select;
        logic mem_ir_select;
        logic compliment_or_adder;
        logic a_pc_enable;
        logic mem_ir_enable;
        logic adder_compliment_enable;
    } ctrl_t;

    // Moore decode: the strobes of a state, qualified by the captured opcode
    function automatic ctrl_t decode(input state_t s, input logic [2:0] op);
        ctrl_t c;
        c                         = '0;
        c.busy                    = s != S_IDLE;
        c.done                    = s == S_DONE;
        c.bload                   = s == S_LOAD_B;
        c.mem_ir_enable           = s == S_LOAD_B;
        c.mem_ir_select           = s == S_LOAD_B && op != OP_PCREL;
        c.areset                  = (s == S_LOAD_B && op == OP_LDA) || s == S_CLEAR;
        c.breset                  = s == S_CLEAR;
        c.a_pc_enable             = s == S_EXEC;
        c.adder_compliment_enable = s == S_EXEC;
        c.latch_a_load            = s == S_EXEC;
        c.a_pc_select             = s == S_EXEC && op != OP_PCREL;
        c.compliment_or_adder     = s == S_EXEC && op == OP_NOT;
        c.aload                   = s == S_WRITE_A;
        return c;
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: Moore FSM sequencing ALU datapath strobes per opcode
//   clk, reset (async, active-high), start/opcode request, carry from datapath;
//   datapath strobes, busy, done pulse, c_flag (carry of last ADD), sticky illegal.
module alu_sequencer
    import enkel_pkg::*;
#(
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [OPW-1:0] opcode,
    input  logic           carry,
    output logic           Aload,
    output logic           Bload,
    output logic           Areset,
    output logic           Breset,
    output logic           latch_A_load,
    output logic           A_PC_select,
    output logic           MEM_IR_select,
    output logic           compliment_or_adder,
    output logic           A_PC_enable,
    output logic           mem_IR_enable,
    output logic           adder_compliment_enable,
    output logic           busy,
    output logic           done,
    output logic           c_flag,
    output logic           illegal
);

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    ctrl_t          ctrl_q;
    logic           c_flag_q, illegal_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: if (start) begin
                op_d    = opcode;
                state_d = opcode == OP_CLR ? S_CLEAR :
                          (opcode == OP_NOP || opcode > OP_PCREL) ? S_DONE : S_LOAD_B;
            end
            S_LOAD_B:          state_d = S_EXEC;
            S_EXEC:            state_d = op_q == OP_PCREL ? S_DONE : S_WRITE_A;
            S_WRITE_A, S_CLEAR: state_d = S_DONE;
            default:           state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with state_q
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            ctrl_q    <= '0;
            c_flag_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctrl_q  <= decode(state_d, op_d);
            if (state_q == S_WRITE_A && op_q == OP_ADD) c_flag_q <= carry;
            if (state_q == S_IDLE && start && opcode > OP_PCREL) illegal_q <= 1'b1;
        end
    end

    assign Aload                   = ctrl_q.aload;
    assign Bload                   = ctrl_q.bload;
    assign Areset                  = ctrl_q.areset;
    assign Breset                  = ctrl_q.breset;
    assign latch_A_load            = ctrl_q.latch_a_load;
    assign A_PC_select             = ctrl_q.a_pc_select;
    assign MEM_IR_select           = ctrl_q.mem_ir_select;
    assign compliment_or_adder     = ctrl_q.compliment_or_adder;
    assign A_PC_enable             = ctrl_q.a_pc_enable;
    assign mem_IR_enable           = ctrl_q.mem_ir_enable;
    assign adder_compliment_enable = ctrl_q.adder_compliment_enable;
    assign busy                    = ctrl_q.busy;
    assign done                    = ctrl_q.done;
    assign c_flag                  = c_flag_q;
    assign illegal                 = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed table-driven checks of alu_sequencer strobe sequences
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, carry;
    logic [2:0] opcode;
    logic       Aload, Bload, Areset, Breset, latch_A_load, A_PC_select, MEM_IR_select;
    logic       compliment_or_adder, A_PC_enable, mem_IR_enable, adder_compliment_enable;
    logic       busy, done, c_flag, illegal;
    logic [12:0] obs;
    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.OPW(3)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .carry(carry),
        .Aload(Aload), .Bload(Bload), .Areset(Areset), .Breset(Breset),
        .latch_A_load(latch_A_load), .A_PC_select(A_PC_select), .MEM_IR_select(MEM_IR_select),
        .compliment_or_adder(compliment_or_adder), .A_PC_enable(A_PC_enable),
        .mem_IR_enable(mem_IR_enable), .adder_compliment_enable(adder_compliment_enable),
        .busy(busy), .done(done), .c_flag(c_flag), .illegal(illegal)
    );

    assign obs = {busy, done, Aload, Bload, Areset, Breset, latch_A_load, A_PC_select,
                  MEM_IR_select, compliment_or_adder, A_PC_enable, mem_IR_enable,
                  adder_compliment_enable};

    localparam logic [12:0] BSY = 13'h1000, DNE = 13'h0800, ALD = 13'h0400, BLD = 13'h0200;
    localparam logic [12:0] ARS = 13'h0100, BRS = 13'h0080, LAL = 13'h0040, APS = 13'h0020;
    localparam logic [12:0] MIS = 13'h0010, COA = 13'h0008, APE = 13'h0004, MIE = 13'h0002;
    localparam logic [12:0] ACE = 13'h0001, Z = 13'h0000;
    localparam logic [12:0] LB  = BSY | BLD | MIE | MIS;
    localparam logic [12:0] LBP = BSY | BLD | MIE;
    localparam logic [12:0] EX  = BSY | APE | ACE | LAL | APS;
    localparam logic [12:0] EXP = BSY | APE | ACE | LAL;
    localparam logic [12:0] WA  = BSY | ALD;
    localparam logic [12:0] DN  = BSY | DNE;
    localparam logic [12:0] CL  = BSY | ARS | BRS;

    typedef struct {
        string            name;
        logic [2:0]       op;
        logic             cy;
        logic [0:4][12:0] w;
        logic             c;
        logic             ill;
    } vec_t;

    vec_t vecs[11];
    vec_t post;

    task automatic check(input string n, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        start  = 1'b1;
        opcode = v.op;
        carry  = v.cy;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start  = 1'b0;
            opcode = ~v.op;
            check($sformatf("%s_cyc%0d", v.name, k + 1), obs, v.w[k]);
        end
        check({v.name, "_c_flag"}, {12'b0, c_flag}, {12'b0, v.c});
        check({v.name, "_illegal"}, {12'b0, illegal}, {12'b0, v.ill});
    endtask

    initial begin
        vecs[0]  = '{"add_c1",  3'd2, 1'b1, {LB, EX, WA, DN, Z},        1'b1, 1'b0};
        vecs[1]  = '{"pcrel",   3'd5, 1'b0, {LBP, EXP, DN, Z, Z},       1'b1, 1'b0};
        vecs[2]  = '{"not",     3'd3, 1'b0, {LB, EX | COA, WA, DN, Z},  1'b1, 1'b0};
        vecs[3]  = '{"clr",     3'd4, 1'b0, {CL, DN, Z, Z, Z},          1'b1, 1'b0};
        vecs[4]  = '{"nop",     3'd0, 1'b0, {DN, Z, Z, Z, Z},           1'b1, 1'b0};
        vecs[5]  = '{"ill7",    3'd7, 1'b0, {DN, Z, Z, Z, Z},           1'b1, 1'b1};
        vecs[6]  = '{"nop2",    3'd0, 1'b0, {DN, Z, Z, Z, Z},           1'b1, 1'b1};
        vecs[7]  = '{"lda",     3'd1, 1'b0, {LB | ARS, EX, WA, DN, Z},  1'b1, 1'b1};
        vecs[8]  = '{"add_c0",  3'd2, 1'b0, {LB, EX, WA, DN, Z},        1'b0, 1'b1};
        vecs[9]  = '{"ill6",    3'd6, 1'b1, {DN, Z, Z, Z, Z},           1'b0, 1'b1};
        vecs[10] = '{"add_c1b", 3'd2, 1'b1, {LB, EX, WA, DN, Z},        1'b1, 1'b1};
        post     = '{"post_rst_add", 3'd2, 1'b0, {LB, EX, WA, DN, Z},   1'b0, 1'b0};

        reset  = 1'b1;
        start  = 1'b1;
        opcode = 3'd2;
        carry  = 1'b1;
        #12;
        check("reset_outputs", obs, Z);
        check("reset_c_flag", {12'b0, c_flag}, Z);
        check("reset_illegal", {12'b0, illegal}, Z);
        @(negedge clk);
        check("reset_held", obs, Z);
        start = 1'b0;
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // NOT followed by CLR with start held: second request waits for IDLE
        @(negedge clk);
        start  = 1'b1;
        opcode = 3'd3;
        carry  = 1'b0;
        @(negedge clk);
        opcode = 3'd4;
        check("held_lb", obs, LB);
        @(negedge clk);
        check("held_ex_not", obs, EX | COA);
        @(negedge clk);
        check("held_wa", obs, WA);
        @(negedge clk);
        check("held_done", obs, DN);
        @(negedge clk);
        check("held_idle", obs, Z);
        @(negedge clk);
        start = 1'b0;
        check("held_clear", obs, CL);
        @(negedge clk);
        check("held_clr_done", obs, DN);
        @(negedge clk);
        check("held_end_idle", obs, Z);

        // reset in EXEC of an ADD aborts at once
        @(negedge clk);
        start  = 1'b1;
        opcode = 3'd2;
        carry  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_lb", obs, LB);
        @(negedge clk);
        check("abort_ex", obs, EX);
        reset = 1'b1;
        #1;
        check("abort_outputs", obs, Z);
        check("abort_c_flag", {12'b0, c_flag}, Z);
        check("abort_illegal", {12'b0, illegal}, Z);
        @(negedge clk);
        check("abort_held", obs, Z);
        reset = 1'b0;
        run_vec(post);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
